uart_rx_configurable: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_tick_gen.sv | 37 +++
 rtl/uart_rx_configurable.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_configurable.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM encoding and helpers for the configurable UART receiver.
// UART_RX_BREAK_DETECT_EN adds the WAIT_IDLE state used after a break frame.
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER
`ifdef UART_RX_BREAK_DETECT_EN
        , ST_WAIT_IDLE
`endif
    } state_e;

    // Returns 0 for an illegal oversampling ratio so the caller's DIV < 2 check fires.
    function automatic int calc_div(int clk_hz, int baud, int os);
        return (baud < 1 || os < 4 || os > 32) ? 0 : clk_hz / (baud * os);
    endfunction

    function automatic logic majority(logic a, logic b, logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: oversampling tick divider with synchronous clear; tick_idx is the
// 1-based index (wrapping to 0 at OVERSAMPLE) of the tick being emitted.
module uart_rx_tick_gen #(
    parameter int DIV        = 10,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          tick,
    output logic [$clog2(OVERSAMPLE)-1:0] tick_idx
);
    localparam int DW = $clog2(DIV);
    localparam int IW = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(OVERSAMPLE - 1);

    logic [DW-1:0] div_q, div_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        tick     = !clr && div_q == DIV_LAST;
        tick_idx = idx_q == IDX_LAST ? '0 : idx_q + IW'(1);
        div_d    = (clr || div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        idx_d    = clr ? '0 : tick ? tick_idx : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/uart_rx_configurable.sv
// uart_rx_configurable: parametrised oversampled UART receiver with 3-sample majority vote,
// valid/ready output and per-frame error flags; UART_RX_BREAK_DETECT_EN adds RxBreak.
module uart_rx_configurable
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 RxWire,
    output logic [DATA_BITS-1:0] RxDataOutput,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 RxParityError,
    output logic                 RxFrameError,
    output logic                 RxOverrun,
    output logic                 RxBusy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 RxBreak
`endif
);
    localparam int DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int IW  = $clog2(OVERSAMPLE);
    localparam logic [IW-1:0] MID_A = IW'(OVERSAMPLE / 2 - 1);
    localparam logic [IW-1:0] MID_B = IW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0] MID_C = IW'(OVERSAMPLE / 2 + 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);
    localparam logic [5:0] STOP_LAST = 6'(STOP_BITS - 1);
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [5:0] OS_LAST = 6'(OVERSAMPLE - 1);
`endif

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_cfg_err
        $error("uart_rx_configurable: illegal configuration");
    end

    logic                 sync1_q, sync1_d, sync2_q, sync2_d, s_prev_q, s_prev_d;
    state_e               state_q, state_d;
    logic [1:0]           vote_q, vote_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_err_q, par_err_d, frame_err_q, frame_err_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 ovr_q, ovr_d, busy_q, busy_d;
    logic                 tick, s, v, mid;
    logic [IW-1:0]        tick_idx;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 par_bit_q, par_bit_d, brk_q, brk_d, is_break;
`endif

    uart_rx_tick_gen #(.DIV(DIV), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk     (Clk),
        .rst     (Reset),
        .clr     (state_q == ST_IDLE),
        .tick    (tick),
        .tick_idx(tick_idx)
    );

    // Bit decision lands on the third vote sample; earlier two are held in vote_q.
    assign s   = sync2_q;
    assign v   = majority(vote_q[1], vote_q[0], s);
    assign mid = tick && tick_idx == MID_C;

    always_comb begin
        sync1_d     = RxWire;
        sync2_d     = sync1_q;
        s_prev_d    = s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        vote_d      = (tick && (tick_idx == MID_A || tick_idx == MID_B)) ? {vote_q[0], s} : vote_q;
        valid_d     = valid_q && !RxReady;
        ovr_d       = ovr_q && !(valid_q && RxReady);
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d   = par_bit_q;
        brk_d       = brk_q;
        is_break    = shift_q == '0 && !par_bit_q && frame_err_q;
`endif
        case (state_q)
            ST_IDLE: if (s_prev_q && !s) begin
                state_d     = ST_START;
                cnt_d       = '0;
                par_err_d   = 1'b0;
                frame_err_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                par_bit_d   = 1'b0;
`endif
            end
            ST_START: if (mid) state_d = v ? ST_IDLE : ST_DATA;
            ST_DATA: if (mid) begin
                shift_d = {v, shift_q[DATA_BITS-1:1]};
                cnt_d   = cnt_q == DATA_LAST ? '0 : cnt_q + 6'd1;
                state_d = cnt_q != DATA_LAST ? ST_DATA :
                          PARITY_MODE != PARITY_NONE ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (mid) begin
                par_err_d = (^shift_q ^ v) ^ (PARITY_MODE == PARITY_ODD);
`ifdef UART_RX_BREAK_DETECT_EN
                par_bit_d = v;
`endif
                state_d   = ST_STOP;
            end
            ST_STOP: if (mid) begin
                frame_err_d = frame_err_q | ~v;
                cnt_d       = cnt_q + 6'd1;
                state_d     = cnt_q == STOP_LAST ? ST_DELIVER : ST_STOP;
            end
            ST_DELIVER: begin
                if (!valid_q || RxReady) begin
                    data_d  = shift_q;
                    perr_d  = par_err_q;
                    ferr_d  = frame_err_q;
                    valid_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    brk_d   = is_break;
`endif
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                cnt_d   = '0;
                if (is_break) state_d = ST_WAIT_IDLE;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            ST_WAIT_IDLE: begin
                cnt_d = !s ? '0 : tick ? cnt_q + 6'd1 : cnt_q;
                if (s && tick && cnt_q == OS_LAST) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            s_prev_q    <= 1'b1;
            state_q     <= ST_IDLE;
            vote_q      <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q   <= 1'b0;
            brk_q       <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            s_prev_q    <= s_prev_d;
            state_q     <= state_d;
            vote_q      <= vote_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q   <= par_bit_d;
            brk_q       <= brk_d;
`endif
        end
    end

    assign RxDataOutput  = data_q;
    assign RxValid       = valid_q;
    assign RxParityError = perr_q;
    assign RxFrameError  = ferr_q;
    assign RxOverrun     = ovr_q;
    assign RxBusy        = busy_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign RxBreak       = brk_q;
`endif
endmodule

// File: tb/tb_uart_rx_configurable.sv
// tb_uart_rx_configurable: table-driven and randomized frames on 8N1, 8E1 and 7O2 receivers
// checked against a frame-level model; UART_RX_BREAK_DETECT_EN also exercises RxBreak.
module tb_uart_rx_configurable;
    localparam int BIT = 160;
    localparam int NV  = 12;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       pbit;
        logic       stop0;
        logic [8:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        int         inst;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] line = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] v, pe, fe, ov, bz;
`ifdef UART_RX_BREAK_DETECT_EN
    logic [2:0] brk;
    int         brk_cnt = 0;
`endif

    int   checks = 0;
    int   failures = 0;
    rec_t got[$];
    vec_t vecs[NV];

    always #5 Clk = ~Clk;

    uart_rx_configurable #(.CLOCK_FREQUENCY(1_536_000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                           .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n (
        .Clk(Clk), .Reset(Reset), .RxWire(line[0]), .RxDataOutput(d0), .RxValid(v[0]),
        .RxReady(rdy[0]), .RxParityError(pe[0]), .RxFrameError(fe[0]), .RxOverrun(ov[0]),
        .RxBusy(bz[0])
`ifdef UART_RX_BREAK_DETECT_EN
        , .RxBreak(brk[0])
`endif
    );

    uart_rx_configurable #(.CLOCK_FREQUENCY(1_536_000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                           .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_e (
        .Clk(Clk), .Reset(Reset), .RxWire(line[1]), .RxDataOutput(d1), .RxValid(v[1]),
        .RxReady(rdy[1]), .RxParityError(pe[1]), .RxFrameError(fe[1]), .RxOverrun(ov[1]),
        .RxBusy(bz[1])
`ifdef UART_RX_BREAK_DETECT_EN
        , .RxBreak(brk[1])
`endif
    );

    uart_rx_configurable #(.CLOCK_FREQUENCY(1_536_000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                           .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_o (
        .Clk(Clk), .Reset(Reset), .RxWire(line[2]), .RxDataOutput(d2), .RxValid(v[2]),
        .RxReady(rdy[2]), .RxParityError(pe[2]), .RxFrameError(fe[2]), .RxOverrun(ov[2]),
        .RxBusy(bz[2])
`ifdef UART_RX_BREAK_DETECT_EN
        , .RxBreak(brk[2])
`endif
    );

    // Every accepted frame (valid && ready seen between edges) is logged for comparison.
    always @(negedge Clk) begin
        if (v[0] && rdy[0]) got.push_back(rec_t'{0, 9'(d0), pe[0], fe[0]});
        if (v[1] && rdy[1]) got.push_back(rec_t'{1, 9'(d1), pe[1], fe[1]});
        if (v[2] && rdy[2]) got.push_back(rec_t'{2, 9'(d2), pe[2], fe[2]});
`ifdef UART_RX_BREAK_DETECT_EN
        if (v[0] && rdy[0] && brk[0]) brk_cnt++;
`endif
    end

    function automatic int dbits(int i);
        return i == 2 ? 7 : 8;
    endfunction

    function automatic int pmode(int i);
        return i == 0 ? 0 : i == 1 ? 2 : 1;
    endfunction

    function automatic int nstop(int i);
        return i == 2 ? 2 : 1;
    endfunction

    function automatic logic model_perr(int i, logic [8:0] data, logic pbit);
        int ones;
        ones = $countones(data) + int'(pbit);
        return pmode(i) == 0 ? 1'b0 : pmode(i) == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_time(int i, logic lvl, int n);
        line[i] = lvl;
        repeat (n * BIT) @(negedge Clk);
    endtask

    task automatic send(int i, logic [8:0] data, logic pbit, logic stop0);
        bit_time(i, 1'b0, 1);
        for (int b = 0; b < dbits(i); b++) bit_time(i, data[b], 1);
        if (pmode(i) != 0) bit_time(i, pbit, 1);
        for (int s = 0; s < nstop(i); s++) bit_time(i, !(stop0 && s == nstop(i) - 1), 1);
        line[i] = 1'b1;
    endtask

    task automatic expect_frame(string tag, int i, logic [8:0] d, logic epe, logic efe);
        rec_t r;
        r = '{-1, 9'h1FF, 1'bx, 1'bx};
        check($sformatf("%s.count", tag), got.size(), 1);
        if (got.size() != 0) r = got.pop_front();
        check($sformatf("%s.inst", tag), r.inst, i);
        check($sformatf("%s.data", tag), 32'(r.d), 32'(d));
        check($sformatf("%s.perr", tag), 32'(r.pe), 32'(epe));
        check($sformatf("%s.ferr", tag), 32'(r.fe), 32'(efe));
        got.delete();
    endtask

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h03C, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b0};
        vecs[2] = '{1, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0};
        vecs[3] = '{2, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};
        for (int k = 4; k < NV; k++) begin
            vecs[k].inst   = $urandom_range(0, 2);
            vecs[k].data   = 9'($urandom) & 9'((1 << dbits(vecs[k].inst)) - 1);
            vecs[k].pbit   = 1'($urandom_range(0, 1));
            vecs[k].stop0  = $urandom_range(0, 3) == 0;
            vecs[k].exp_d  = vecs[k].data;
            vecs[k].exp_pe = model_perr(vecs[k].inst, vecs[k].data, vecs[k].pbit);
            vecs[k].exp_fe = vecs[k].stop0;
        end

        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset.valid%0d", i), 32'(v[i]), 0);
            check($sformatf("reset.busy%0d", i), 32'(bz[i]), 0);
            check($sformatf("reset.ovr%0d", i), 32'(ov[i]), 0);
            check($sformatf("reset.errs%0d", i), 32'({pe[i], fe[i]}), 0);
        end
        check("reset.data", 32'({d0, d1, d2}), 0);

        for (int k = 0; k < NV; k++) begin
            send(vecs[k].inst, vecs[k].data, vecs[k].pbit, vecs[k].stop0);
            repeat (2 * BIT) @(negedge Clk);
            expect_frame($sformatf("vec%0d", k), vecs[k].inst, vecs[k].exp_d, vecs[k].exp_pe,
                         vecs[k].exp_fe);
        end

        line[0] = 1'b0;
        repeat (30) @(negedge Clk);
        check("glitch.busy_mid", 32'(bz[0]), 1);
        repeat (30) @(negedge Clk);
        line[0] = 1'b1;
        repeat (70) @(negedge Clk);
        check("glitch.busy_end", 32'(bz[0]), 0);
        repeat (200) @(negedge Clk);
        check("glitch.frames", got.size(), 0);

        rdy[0] = 1'b0;
        send(0, 9'h011, 1'b0, 1'b0);
        repeat (BIT) @(negedge Clk);
        check("ovr.first_valid", 32'(v[0]), 1);
        check("ovr.first_ovr", 32'(ov[0]), 0);
        send(0, 9'h022, 1'b0, 1'b0);
        repeat (BIT) @(negedge Clk);
        check("ovr.held_valid", 32'(v[0]), 1);
        check("ovr.held_data", 32'(d0), 32'h11);
        check("ovr.flag", 32'(ov[0]), 1);
        #1 rdy[0] = 1'b1;
        @(negedge Clk);
        #1 rdy[0] = 1'b0;
        check("ovr.valid_drop", 32'(v[0]), 0);
        check("ovr.flag_clear", 32'(ov[0]), 0);
        got.delete();

        send(0, 9'h033, 1'b0, 1'b0);
        repeat (BIT) @(negedge Clk);
        check("rst.pre_data", 32'(d0), 32'h33);
        bit_time(0, 1'b0, 1);
        for (int b = 0; b < 4; b++) bit_time(0, b % 2 == 0, 1);
        line[0] = 1'b1;
        repeat (80) @(negedge Clk);
        check("rst.busy_mid", 32'(bz[0]), 1);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst.busy", 32'(bz[0]), 0);
        check("rst.valid", 32'(v[0]), 0);
        check("rst.data", 32'(d0), 0);
        check("rst.flags", 32'({ov[0], pe[0], fe[0]}), 0);
        Reset = 1'b0;
        rdy[0] = 1'b1;
        repeat (2 * BIT) @(negedge Clk);
        got.delete();
        send(0, 9'h00F, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge Clk);
        expect_frame("rst.next", 0, 9'h00F, 1'b0, 1'b0);

`ifdef UART_RX_BREAK_DETECT_EN
        brk_cnt = 0;
        bit_time(0, 1'b0, 20);
        bit_time(0, 1'b1, 3);
        check("brk.count", brk_cnt, 1);
        expect_frame("brk.frame", 0, 9'h000, 1'b0, 1'b1);
        check("brk.idle", 32'(bz[0]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
